// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage pipeline hazard controller:
// opcode constants, forwarding-select encoding and controller FSM states.
package pipe_pkg;

    // Base-ISA major opcodes seen by the hazard logic
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // EX operand source select
    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    // Controller states
    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } state_e;

    // Decoder helper for the ID stage: which sources an opcode reads, {use_rs2, use_rs1}.
    function automatic logic [1:0] op_src_use(input logic [6:0] opcode);
        case (opcode)
            OP_RTYPE, OP_STORE, OP_BRANCH: return 2'b11;
            OP_ITYPE, OP_LOAD:             return 2'b01;
            OP_JAL:                        return 2'b00;
            default:                       return 2'b00; // bubbles read nothing
        endcase
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational RAW hit detection and forwarding-select generation for the
// two ID-stage source operands against the EX and MEM destinations.
// Build option: PIPE_FWD_EN enables forwarding (only load-use stalls);
// without it every EX/MEM hit stalls and the selects stay at the regfile.
module hazard_fwd_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_wen,
    input  logic              ex_load,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_wen,
    output logic              stall_need,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel
);

    logic [REG_AW-1:0] src [2];
    logic              use_src [2];
    logic [1:0]        ex_hit;
    logic [1:0]        mem_hit;

    assign src[0]     = id_rs1;
    assign src[1]     = id_rs2;
    assign use_src[0] = id_use_rs1;
    assign use_src[1] = id_use_rs2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            // x0 is hardwired zero, so it never produces a hit
            assign ex_hit[gi]  = ex_wen  & (ex_rd  != '0) & (ex_rd  == src[gi]) & use_src[gi];
            assign mem_hit[gi] = mem_wen & (mem_rd != '0) & (mem_rd == src[gi]) & use_src[gi];
        end
    endgenerate

`ifdef PIPE_FWD_EN
    logic [1:0] sel [2];

    generate
        for (gi = 0; gi < 2; gi++) begin : g_sel
            // Youngest producer wins: EX result over MEM writeback data
            assign sel[gi] = ex_hit[gi]  ? FWD_EXMEM :
                             mem_hit[gi] ? FWD_MEMWB : FWD_RF;
        end
    endgenerate

    // Only a load in EX cannot be forwarded in time
    assign stall_need = ex_load & (|ex_hit);
    assign fwd_a_sel  = sel[0];
    assign fwd_b_sel  = sel[1];
`else
    logic unused_load;

    // Without bypass paths the consumer waits until the producer has left MEM
    assign stall_need  = (|ex_hit) | (|mem_hit);
    assign fwd_a_sel   = FWD_RF;
    assign fwd_b_sel   = FWD_RF;
    assign unused_load = ex_load;
`endif

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the IF/ID/EX/MEM/WB pipeline: stall/bubble on RAW
// hazards, one-cycle flush after a redirect, registered forwarding selects,
// and saturating stall/flush event counters.
// Build option: PIPE_FWD_EN (forwarding enabled; see hazard_fwd_unit).
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_wen,
    input  logic              ex_load,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_wen,
    input  logic              redirect,
    output logic              pc_hold,
    output logic              if_id_hold,
    output logic              id_ex_bubble,
    output logic              flush_if_id,
    output logic              flush_ex_mem,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events
);

    state_e                 state_reg;
    state_e                 state_next;
    logic                   stall_need;
    logic                   stall_act;
    logic                   flush_act;
    logic [1:0]             fwd_a_sel;
    logic [1:0]             fwd_b_sel;
    logic [1:0]             fwd_a_reg;
    logic [1:0]             fwd_b_reg;
    logic [1:0]             cnt_inc;
    logic [1:0][CNT_W-1:0]  cnt_out;

    hazard_fwd_unit #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_rd      (ex_rd),
        .ex_wen     (ex_wen),
        .ex_load    (ex_load),
        .mem_rd     (mem_rd),
        .mem_wen    (mem_wen),
        .stall_need (stall_need),
        .fwd_a_sel  (fwd_a_sel),
        .fwd_b_sel  (fwd_b_sel)
    );

    // Controller state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and strobe generation; a redirect always pre-empts a stall
    always_comb begin
        state_next = state_reg;
        stall_act  = 1'b0;
        flush_act  = 1'b0;
        case (state_reg)
            RUN: begin
                if (redirect) begin
                    state_next = FLUSH;
                end else if (stall_need) begin
                    stall_act  = 1'b1;
                    state_next = STALL;
                end
            end
            STALL: begin
                if (redirect) begin
                    state_next = FLUSH;
                end else if (stall_need) begin
                    stall_act = 1'b1;
                end else begin
                    state_next = RUN;
                end
            end
            FLUSH: begin
                // Hazards are masked here: the ID instruction is being squashed
                flush_act  = 1'b1;
                state_next = redirect ? FLUSH : RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // Live hazard inputs must not leak a stall strobe while reset is held
    assign pc_hold      = stall_act & ~rst;
    assign if_id_hold   = stall_act & ~rst;
    assign id_ex_bubble = (stall_act & ~rst) | flush_act;
    assign flush_if_id  = flush_act;
    assign flush_ex_mem = flush_act;

    // Forwarding selects follow the instruction into EX; a bubble carries none
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_a_reg <= FWD_RF;
            fwd_b_reg <= FWD_RF;
        end else if (id_ex_bubble) begin
            fwd_a_reg <= FWD_RF;
            fwd_b_reg <= FWD_RF;
        end else if (!if_id_hold) begin
            fwd_a_reg <= fwd_a_sel;
            fwd_b_reg <= fwd_b_sel;
        end
    end

    assign fwd_a = fwd_a_reg;
    assign fwd_b = fwd_b_reg;

    // Counter 0 counts held-PC cycles, counter 1 counts redirects
    assign cnt_inc = {redirect, pc_hold};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;

            // Saturating event counter
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign cnt_out[gi] = cnt_reg;
        end
    endgenerate

    assign stall_cycles = cnt_out[0];
    assign flush_events = cnt_out[1];

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// randomized traffic, compared cycle by cycle with a behavioural model.
// A second instance with 4-bit counters exercises saturation.
module tb_pipeline_hazard_ctrl;

`ifdef PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
    logic       id_use_rs1, id_use_rs2, ex_wen, ex_load, mem_wen, redirect;

    logic        pc_hold, if_id_hold, id_ex_bubble, flush_if_id, flush_ex_mem;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cycles, flush_events;

    logic        s_pc_hold, s_if_id_hold, s_id_ex_bubble, s_flush_if_id, s_flush_ex_mem;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [3:0]  s_stall_cycles, s_flush_events;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    // Behavioural model state
    bit          m_flush_pend;
    logic [1:0]  m_fa, m_fb;
    longint      m_stall, m_flush, m_stall4, m_flush4;

    pipeline_hazard_ctrl #(.CNT_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_load(ex_load),
        .mem_rd(mem_rd), .mem_wen(mem_wen), .redirect(redirect),
        .pc_hold(pc_hold), .if_id_hold(if_id_hold), .id_ex_bubble(id_ex_bubble),
        .flush_if_id(flush_if_id), .flush_ex_mem(flush_ex_mem),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    pipeline_hazard_ctrl #(.CNT_W(4), .REG_AW(5)) dut_sat (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_load(ex_load),
        .mem_rd(mem_rd), .mem_wen(mem_wen), .redirect(redirect),
        .pc_hold(s_pc_hold), .if_id_hold(s_if_id_hold), .id_ex_bubble(s_id_ex_bubble),
        .flush_if_id(s_flush_if_id), .flush_ex_mem(s_flush_ex_mem),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .stall_cycles(s_stall_cycles), .flush_events(s_flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input logic [4:0] s, input bit use_s, input logic [4:0] rd, input bit wen);
        return wen && use_s && (rd != 5'd0) && (rd == s);
    endfunction

    function automatic longint sat_inc(input longint v, input longint max_v, input bit inc);
        if (!inc || v >= max_v) return v;
        return v + 1;
    endfunction

    // Select the operand source the spec asks for: youngest producer first
    function automatic logic [1:0] exp_sel(input bit h_ex, input bit h_mem);
        if (!FWD)  return 2'd0;
        if (h_ex)  return 2'd1;
        if (h_mem) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_flush_pend = 1'b0;
        m_fa = 2'd0; m_fb = 2'd0;
        m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
    endtask

    task automatic set_in(input int rs1, input int rs2, input bit u1, input bit u2,
                          input int exrd, input bit exwen, input bit exld,
                          input int memrd, input bit memwen, input bit redir);
        id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_use_rs1 = u1; id_use_rs2 = u2;
        ex_rd = 5'(exrd); ex_wen = exwen; ex_load = exld;
        mem_rd = 5'(memrd); mem_wen = memwen; redirect = redir;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".pc_hold"},      pc_hold,      0);
        check_eq({tag, ".if_id_hold"},   if_id_hold,   0);
        check_eq({tag, ".id_ex_bubble"}, id_ex_bubble, 0);
        check_eq({tag, ".flush_if_id"},  flush_if_id,  0);
        check_eq({tag, ".flush_ex_mem"}, flush_ex_mem, 0);
        check_eq({tag, ".fwd_a"},        fwd_a,        0);
        check_eq({tag, ".fwd_b"},        fwd_b,        0);
        check_eq({tag, ".stall_cycles"}, stall_cycles, 0);
        check_eq({tag, ".flush_events"}, flush_events, 0);
        check_eq({tag, ".sat_stall"},    s_stall_cycles, 0);
        check_eq({tag, ".sat_pc_hold"},  s_pc_hold,    0);
    endtask

    // One pipeline cycle: called at a negedge with inputs applied, returns at the next negedge
    task automatic tick(input string tag);
        bit h1e, h2e, h1m, h2m, need, stall, bub;
        h1e = hit(id_rs1, id_use_rs1, ex_rd, ex_wen);
        h2e = hit(id_rs2, id_use_rs2, ex_rd, ex_wen);
        h1m = hit(id_rs1, id_use_rs1, mem_rd, mem_wen);
        h2m = hit(id_rs2, id_use_rs2, mem_rd, mem_wen);
        need  = FWD ? (ex_load && (h1e || h2e)) : (h1e || h2e || h1m || h2m);
        stall = need && !redirect && !m_flush_pend;
        bub   = stall || m_flush_pend;
        #2;
        check_eq({tag, ".pc_hold"},      pc_hold,      stall);
        check_eq({tag, ".if_id_hold"},   if_id_hold,   stall);
        check_eq({tag, ".id_ex_bubble"}, id_ex_bubble, bub);
        check_eq({tag, ".flush_if_id"},  flush_if_id,  m_flush_pend);
        check_eq({tag, ".flush_ex_mem"}, flush_ex_mem, m_flush_pend);
        check_eq({tag, ".fwd_a"},        fwd_a,        m_fa);
        check_eq({tag, ".fwd_b"},        fwd_b,        m_fb);
        check_eq({tag, ".stall_cycles"}, stall_cycles, 32'(m_stall));
        check_eq({tag, ".flush_events"}, flush_events, 32'(m_flush));
        check_eq({tag, ".sat_stall"},    s_stall_cycles, 32'(m_stall4));
        check_eq({tag, ".sat_flush"},    s_flush_events, 32'(m_flush4));
        $display("txn %0d %s rs1=%0d/%0b rs2=%0d/%0b ex=%0d/%0b/%0b mem=%0d/%0b redir=%0b hold=%0b bub=%0b flush=%0b fwd=%0d/%0d stalls=%0d flushes=%0d",
                 n_txn, tag, id_rs1, id_use_rs1, id_rs2, id_use_rs2, ex_rd, ex_wen, ex_load,
                 mem_rd, mem_wen, redirect, pc_hold, id_ex_bubble, flush_if_id,
                 fwd_a, fwd_b, stall_cycles, flush_events);
        n_txn++;
        @(posedge clk);
        m_stall  = sat_inc(m_stall,  64'hFFFF_FFFF, stall);
        m_flush  = sat_inc(m_flush,  64'hFFFF_FFFF, redirect);
        m_stall4 = sat_inc(m_stall4, 15, stall);
        m_flush4 = sat_inc(m_flush4, 15, redirect);
        if (bub) begin
            m_fa = 2'd0;
            m_fb = 2'd0;
        end else begin
            m_fa = exp_sel(h1e, h1m);
            m_fb = exp_sel(h2e, h2m);
        end
        m_flush_pend = redirect;
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(tag);
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Load-use on rs1=x5, then the load moves to MEM
        set_in(5, 0, 1, 0, 5, 1, 1, 0, 0, 0); tick("load_use");
        set_in(5, 0, 1, 0, 0, 0, 0, 5, 1, 0); tick("load_use_mem");
        idle("load_use_ex");
        idle("idle");

        // ALU result consumed by the next instruction on rs2
        set_in(0, 3, 0, 1, 3, 1, 0, 0, 0, 0); tick("alu_b2b");
        idle("alu_b2b_ex");
        // Same through x0: no forwarding, no stall
        set_in(0, 0, 0, 1, 0, 1, 0, 0, 0, 0); tick("alu_x0");
        idle("alu_x0_ex");

        // EX and MEM both produce x7
        set_in(7, 0, 1, 0, 7, 1, 0, 7, 1, 0); tick("double_hit");
        idle("double_hit_ex");

        // Redirect together with a load-use hazard
        set_in(5, 0, 1, 0, 5, 1, 1, 0, 0, 1); tick("redir_hazard");
        set_in(5, 0, 1, 0, 5, 1, 1, 0, 0, 0); tick("redir_flush");
        idle("redir_after");

        // Back-to-back redirects
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick("redir_1");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick("redir_2");
        idle("redir_f2");
        idle("redir_done");

        // Long held hazard saturates the 4-bit stall counter
        for (int i = 0; i < 20; i++) begin
            set_in(9, 9, 1, 1, 9, 1, 1, 9, 1, 0);
            tick("sat_hold");
        end

        // Asynchronous reset in the middle of a stall
        set_in(5, 0, 1, 0, 5, 1, 1, 0, 0, 0); tick("pre_rst");
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid_stall");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        tick("post_rst");
        idle("post_rst_idle");

        // Randomized traffic over a small register window to provoke hits
        for (int i = 0; i < 1500; i++) begin
            set_in($urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                   $urandom_range(0, 3), 1'($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 7) == 0));
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
